// File: rtl/axi4lite_slave_write_buffered.sv
// AXI4-Lite slave write channel with independent AW/W holding registers,
// a command FIFO towards the register back end (valid/ack with timeout)
// and an in-order response FIFO returned on the B channel.
module axi4lite_slave_write_buffered #(
   parameter int AddressWidth = 32,
   parameter int DataWidth    = 32,
   parameter int CmdFifoDepth = 4,
   parameter int AckTimeout   = 256
) (
   input  logic                               ACLK,
   input  logic                               ARESETN,
   input  logic                               AWVALID,
   output logic                               AWREADY,
   input  logic [AddressWidth-1:0]            AWADDR,
   input  logic [2:0]                         AWPROT,
   input  logic                               WVALID,
   output logic                               WREADY,
   input  logic [DataWidth-1:0]               WDATA,
   input  logic [DataWidth/8-1:0]             WSTRB,
   output logic                               BVALID,
   input  logic                               BREADY,
   output logic [1:0]                         BRESP,
   output logic [AddressWidth-1:0]            oWriteAddress,
   output logic [DataWidth-1:0]               oWriteData,
   output logic [DataWidth/8-1:0]             oWriteStrobe,
   output logic                               oWriteValid,
   input  logic                               iWriteAck,
   input  logic                               iWriteError,
   output logic [$clog2(CmdFifoDepth)+1:0]    oOutstanding
);

   localparam int StrbWidth  = DataWidth / 8;
   localparam int IdxWidth   = $clog2(CmdFifoDepth);
   localparam int PtrWidth   = IdxWidth + 1;
   localparam int OutWidth   = IdxWidth + 2;
   localparam int CmdWidth   = AddressWidth + DataWidth + StrbWidth;
   localparam int CountWidth = (AckTimeout > 1) ? $clog2(AckTimeout) : 1;
   localparam logic [CountWidth-1:0] TimeoutLast =
      CountWidth'((AckTimeout > 0) ? AckTimeout - 1 : 0);
   localparam logic [OutWidth-1:0] MaxOutstanding = OutWidth'(2 * CmdFifoDepth);

   logic                    rst_done;
   logic                    aw_held;
   logic                    w_held;
   logic [AddressWidth-1:0] aw_addr;
   logic [DataWidth-1:0]    w_data;
   logic [StrbWidth-1:0]    w_strb;

   logic [CmdWidth-1:0]     cmd_mem [CmdFifoDepth];
   logic [1:0]              resp_mem [CmdFifoDepth];
   logic [PtrWidth-1:0]     cmd_wr;
   logic [PtrWidth-1:0]     cmd_rd;
   logic [PtrWidth-1:0]     resp_wr;
   logic [PtrWidth-1:0]     resp_rd;
   logic [CountWidth-1:0]   ack_count;
   logic [OutWidth-1:0]     outstanding;

   logic                    cmd_empty;
   logic                    cmd_full;
   logic                    resp_empty;
   logic                    resp_full;
   logic                    aw_fire;
   logic                    w_fire;
   logic                    push;
   logic                    write_valid;
   logic                    timeout_hit;
   logic                    pop;
   logic                    b_pop;
   logic [1:0]              resp_in;
   logic [CmdWidth-1:0]     cmd_head;
   logic                    unused_prot;

   // Protection bits carry no meaning for this register block.
   assign unused_prot = ^AWPROT;

   assign cmd_empty  = (cmd_wr == cmd_rd);
   assign cmd_full   = (cmd_wr[PtrWidth-1] != cmd_rd[PtrWidth-1]) &&
                       (cmd_wr[PtrWidth-2:0] == cmd_rd[PtrWidth-2:0]);
   assign resp_empty = (resp_wr == resp_rd);
   assign resp_full  = (resp_wr[PtrWidth-1] != resp_rd[PtrWidth-1]) &&
                       (resp_wr[PtrWidth-2:0] == resp_rd[PtrWidth-2:0]);

   assign AWREADY = rst_done && !aw_held;
   assign WREADY  = rst_done && !w_held;
   assign aw_fire = AWVALID && AWREADY;
   assign w_fire  = WVALID && WREADY;

   // A write is only queued when a response slot is guaranteed for it.
   assign push        = aw_held && w_held && !cmd_full && (outstanding < MaxOutstanding);
   assign write_valid = !cmd_empty && !resp_full;
   assign timeout_hit = (AckTimeout != 0) && write_valid && !iWriteAck &&
                        (ack_count == TimeoutLast);
   assign pop         = write_valid && (iWriteAck || timeout_hit);
   assign resp_in     = (iWriteAck && !iWriteError) ? 2'b00 : 2'b10;
   assign b_pop       = BVALID && BREADY;

   assign cmd_head      = cmd_empty ? '0 : cmd_mem[cmd_rd[IdxWidth-1:0]];
   assign oWriteAddress = cmd_head[CmdWidth-1 -: AddressWidth];
   assign oWriteData    = cmd_head[StrbWidth +: DataWidth];
   assign oWriteStrobe  = cmd_head[StrbWidth-1:0];
   assign oWriteValid   = write_valid;
   assign BVALID        = !resp_empty;
   assign BRESP         = resp_empty ? 2'b00 : resp_mem[resp_rd[IdxWidth-1:0]];
   assign oOutstanding  = outstanding;

   // Ready outputs stay low until the first edge seen with reset released.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) rst_done <= 1'b0;
      else          rst_done <= 1'b1;
   end

   // Address and data holding registers, cleared together when queued.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         aw_addr <= '0;
         w_data  <= '0;
         w_strb  <= '0;
      end else begin
         if (push) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end
         if (aw_fire) begin
            aw_held <= 1'b1;
            aw_addr <= AWADDR;
         end
         if (w_fire) begin
            w_held <= 1'b1;
            w_data <= WDATA;
            w_strb <= WSTRB;
         end
      end
   end

   // FIFO storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge ACLK) begin
      if (push) cmd_mem[cmd_wr[IdxWidth-1:0]] <= {aw_addr, w_data, w_strb};
      if (pop)  resp_mem[resp_wr[IdxWidth-1:0]] <= resp_in;
   end

   // FIFO pointers with natural wrap of the extra MSB.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         cmd_wr  <= '0;
         cmd_rd  <= '0;
         resp_wr <= '0;
         resp_rd <= '0;
      end else begin
         if (push)  cmd_wr  <= cmd_wr + 1'b1;
         if (pop) begin
            cmd_rd  <= cmd_rd + 1'b1;
            resp_wr <= resp_wr + 1'b1;
         end
         if (b_pop) resp_rd <= resp_rd + 1'b1;
      end
   end

   // Counts cycles the head write has waited for its acknowledge.
   always_ff @(posedge ACLK) begin
      if (!ARESETN || pop || !write_valid) ack_count <= '0;
      else if (!iWriteAck)                 ack_count <= ack_count + 1'b1;
   end

   // Writes accepted into the queue but not yet answered on B.
   always_ff @(posedge ACLK) begin
      if (!ARESETN)             outstanding <= '0;
      else if (push && !b_pop)  outstanding <= outstanding + 1'b1;
      else if (!push && b_pop)  outstanding <= outstanding - 1'b1;
   end

endmodule

// File: tb/tb_axi4lite_slave_write_buffered.sv
// Directed bench for axi4lite_slave_write_buffered. One instance uses a short
// acknowledge timeout, the other has the timeout disabled for the
// backpressure scenario; both share all inputs.
module tb_axi4lite_slave_write_buffered;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        AWVALID = 1'b0;
   logic [31:0] AWADDR = '0;
   logic [2:0]  AWPROT = '0;
   logic        WVALID = 1'b0;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        BREADY = 1'b0;
   logic        iWriteAck = 1'b0;
   logic        iWriteError = 1'b0;

   logic        awready, wready, bvalid, wr_valid;
   logic [1:0]  bresp;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;
   logic [3:0]  outstanding;

   logic        nt_awready, nt_wready, nt_bvalid, nt_wr_valid;
   logic [1:0]  nt_bresp;
   logic [31:0] nt_wr_addr, nt_wr_data;
   logic [3:0]  nt_wr_strb;
   logic [3:0]  nt_outstanding;

   int total = 0;
   int bad = 0;
   bit hold6 = 1'b0;

   always #5 ACLK = ~ACLK;

   axi4lite_slave_write_buffered #(
      .AddressWidth(32), .DataWidth(32), .CmdFifoDepth(4), .AckTimeout(8)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .AWVALID(AWVALID), .AWREADY(awready), .AWADDR(AWADDR), .AWPROT(AWPROT),
      .WVALID(WVALID), .WREADY(wready), .WDATA(WDATA), .WSTRB(WSTRB),
      .BVALID(bvalid), .BREADY(BREADY), .BRESP(bresp),
      .oWriteAddress(wr_addr), .oWriteData(wr_data), .oWriteStrobe(wr_strb),
      .oWriteValid(wr_valid), .iWriteAck(iWriteAck), .iWriteError(iWriteError),
      .oOutstanding(outstanding)
   );

   axi4lite_slave_write_buffered #(
      .AddressWidth(32), .DataWidth(32), .CmdFifoDepth(4), .AckTimeout(0)
   ) dut_nt (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .AWVALID(AWVALID), .AWREADY(nt_awready), .AWADDR(AWADDR), .AWPROT(AWPROT),
      .WVALID(WVALID), .WREADY(nt_wready), .WDATA(WDATA), .WSTRB(WSTRB),
      .BVALID(nt_bvalid), .BREADY(BREADY), .BRESP(nt_bresp),
      .oWriteAddress(nt_wr_addr), .oWriteData(nt_wr_data), .oWriteStrobe(nt_wr_strb),
      .oWriteValid(nt_wr_valid), .iWriteAck(iWriteAck), .iWriteError(iWriteError),
      .oOutstanding(nt_outstanding)
   );

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Presents AW and W together and returns in the slot after the capture edge.
   task automatic send(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit nt);
      int n;
      AWVALID = 1'b1; AWADDR = a;
      WVALID  = 1'b1; WDATA = d; WSTRB = s;
      n = 0;
      while (!(nt ? (nt_awready && nt_wready) : (awready && wready)) && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         total++; bad++;
         $display("[TB] FAIL send_ready_timeout: addr %0h never accepted, required acceptance within 50 cycles", a);
      end
      tick();
      AWVALID = 1'b0;
      WVALID  = 1'b0;
   endtask

   task automatic drain();
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
   endtask

   task automatic test_reset();
      ARESETN = 1'b0;
      tick();
      tick();
      total++; if (awready !== 1'b0) begin bad++; $display("[TB] FAIL reset_awready: got %0b required 0", awready); end
      total++; if (wready !== 1'b0) begin bad++; $display("[TB] FAIL reset_wready: got %0b required 0", wready); end
      total++; if (bvalid !== 1'b0 || bresp !== 2'b00) begin bad++; $display("[TB] FAIL reset_b: got valid=%0b resp=%0b required 0/00", bvalid, bresp); end
      total++; if (wr_valid !== 1'b0 || wr_addr !== 32'h0 || wr_data !== 32'h0 || wr_strb !== 4'h0) begin bad++; $display("[TB] FAIL reset_backend: got v=%0b a=%0h d=%0h s=%0h required all 0", wr_valid, wr_addr, wr_data, wr_strb); end
      total++; if (outstanding !== 4'd0) begin bad++; $display("[TB] FAIL reset_outstanding: got %0d required 0", outstanding); end
      ARESETN = 1'b1;
      total++; if (awready !== 1'b0) begin bad++; $display("[TB] FAIL release_before_edge: got %0b required 0", awready); end
      tick();
      total++; if (awready !== 1'b1 || wready !== 1'b1) begin bad++; $display("[TB] FAIL release_ready: got aw=%0b w=%0b required 1/1", awready, wready); end
   endtask

   task automatic test_single_write();
      iWriteAck = 1'b1; iWriteError = 1'b1;
      tick();
      iWriteAck = 1'b0; iWriteError = 1'b0;
      total++; if (bvalid !== 1'b0 || outstanding !== 4'd0) begin bad++; $display("[TB] FAIL stray_ack: got bvalid=%0b out=%0d required 0/0", bvalid, outstanding); end
      AWVALID = 1'b1; AWADDR = 32'h10;
      WVALID = 1'b1; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      total++; if (awready !== 1'b0 || wready !== 1'b0 || wr_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_after_capture: got aw=%0b w=%0b v=%0b required 0/0/0", awready, wready, wr_valid); end
      tick();
      total++; if (wr_valid !== 1'b1 || wr_addr !== 32'h10 || wr_data !== 32'hA5A5A5A5 || wr_strb !== 4'hF) begin bad++; $display("[TB] FAIL single_head: got v=%0b a=%0h d=%0h s=%0h required 1/10/a5a5a5a5/f", wr_valid, wr_addr, wr_data, wr_strb); end
      total++; if (outstanding !== 4'd1) begin bad++; $display("[TB] FAIL single_outstanding: got %0d required 1", outstanding); end
      iWriteAck = 1'b1; iWriteError = 1'b0;
      tick();
      iWriteAck = 1'b0;
      total++; if (bvalid !== 1'b1 || bresp !== 2'b00 || wr_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_resp: got bvalid=%0b resp=%0b v=%0b required 1/00/0", bvalid, bresp, wr_valid); end
      drain();
      total++; if (bvalid !== 1'b0 || outstanding !== 4'd0) begin bad++; $display("[TB] FAIL single_drained: got bvalid=%0b out=%0d required 0/0", bvalid, outstanding); end
   endtask

   task automatic test_decoupled();
      WVALID = 1'b1; WDATA = 32'h1234; WSTRB = 4'h3;
      tick();
      WVALID = 1'b0;
      for (int c = 0; c < 3; c++) begin
         total++; if (awready !== 1'b1 || wready !== 1'b0 || wr_valid !== 1'b0) begin bad++; $display("[TB] FAIL decoupled_wait: cycle %0d got aw=%0b w=%0b v=%0b required 1/0/0", c, awready, wready, wr_valid); end
         if (c < 2) tick();
      end
      AWVALID = 1'b1; AWADDR = 32'h20;
      tick();
      AWVALID = 1'b0;
      tick();
      total++; if (wr_valid !== 1'b1 || wr_addr !== 32'h20 || wr_data !== 32'h1234 || wr_strb !== 4'h3) begin bad++; $display("[TB] FAIL decoupled_head: got v=%0b a=%0h d=%0h s=%0h required 1/20/1234/3", wr_valid, wr_addr, wr_data, wr_strb); end
      iWriteAck = 1'b1;
      tick();
      iWriteAck = 1'b0;
      total++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin bad++; $display("[TB] FAIL decoupled_resp: got bvalid=%0b resp=%0b required 1/00", bvalid, bresp); end
      drain();
   endtask

   task automatic test_error_path();
      send(32'h30, 32'hCAFE, 4'hF, 1'b0);
      tick();
      iWriteAck = 1'b1; iWriteError = 1'b1;
      tick();
      iWriteAck = 1'b0; iWriteError = 1'b0;
      total++; if (bvalid !== 1'b1 || bresp !== 2'b10) begin bad++; $display("[TB] FAIL error_resp: got bvalid=%0b resp=%0b required 1/10", bvalid, bresp); end
      drain();
      send(32'h34, 32'hBEEF, 4'hF, 1'b0);
      tick();
      iWriteAck = 1'b1;
      tick();
      iWriteAck = 1'b0;
      total++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin bad++; $display("[TB] FAIL error_then_clean: got bvalid=%0b resp=%0b required 1/00", bvalid, bresp); end
      drain();
   endtask

   task automatic test_timeout();
      send(32'h40, 32'h1111, 4'hF, 1'b0);
      tick();
      for (int c = 1; c <= 8; c++) begin
         total++; if (wr_valid !== 1'b1) begin bad++; $display("[TB] FAIL timeout_wait: valid cycle %0d got %0b required 1", c, wr_valid); end
         tick();
      end
      total++; if (wr_valid !== 1'b0 || bvalid !== 1'b1 || bresp !== 2'b10) begin bad++; $display("[TB] FAIL timeout_forced: got v=%0b bvalid=%0b resp=%0b required 0/1/10", wr_valid, bvalid, bresp); end
      drain();
      send(32'h44, 32'h2222, 4'hF, 1'b0);
      tick();
      for (int c = 1; c <= 7; c++) tick();
      total++; if (wr_valid !== 1'b1) begin bad++; $display("[TB] FAIL timeout_edge_valid: got %0b required 1", wr_valid); end
      iWriteAck = 1'b1; iWriteError = 1'b0;
      tick();
      iWriteAck = 1'b0;
      total++; if (bvalid !== 1'b1 || bresp !== 2'b00 || outstanding !== 4'd1) begin bad++; $display("[TB] FAIL timeout_ack_priority: got bvalid=%0b resp=%0b out=%0d required 1/00/1", bvalid, bresp, outstanding); end
      drain();
      total++; if (outstanding !== 4'd0) begin bad++; $display("[TB] FAIL timeout_drained: got %0d required 0", outstanding); end
   endtask

   // Drops the pending sixth write once it is captured at this edge.
   task automatic bp_tick();
      bit cap;
      cap = hold6 && nt_awready && nt_wready;
      tick();
      if (cap) begin
         AWVALID = 1'b0; WVALID = 1'b0; hold6 = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [6];
      bit          errs [6];
      int          j;
      int          k;
      for (int i = 0; i < 6; i++) begin
         addrs[i] = 32'h100 + 32'(4 * i);
         errs[i]  = (i == 1) || (i == 4);
      end
      ARESETN = 1'b0;
      tick();
      ARESETN = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) send(addrs[i], 32'hD0000000 + 32'(i), 4'hF, 1'b1);
      total++; if (nt_awready !== 1'b0 || nt_wready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready_low: got aw=%0b w=%0b required 0/0", nt_awready, nt_wready); end
      tick();
      total++; if (nt_awready !== 1'b0 || nt_outstanding !== 4'd4 || nt_wr_addr !== addrs[0]) begin bad++; $display("[TB] FAIL bp_blocked: got aw=%0b out=%0d head=%0h required 0/4/100", nt_awready, nt_outstanding, nt_wr_addr); end
      AWVALID = 1'b1; AWADDR = addrs[5];
      WVALID = 1'b1; WDATA = 32'hD0000005; WSTRB = 4'hF;
      hold6 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++; if (nt_wr_valid !== 1'b1 || nt_wr_addr !== addrs[i]) begin bad++; $display("[TB] FAIL bp_ack_order: ack %0d got v=%0b a=%0h required 1/%0h", i, nt_wr_valid, nt_wr_addr, addrs[i]); end
         iWriteAck = 1'b1; iWriteError = errs[i];
         bp_tick();
         iWriteAck = 1'b0; iWriteError = 1'b0;
         bp_tick();
      end
      total++; if (nt_wr_valid !== 1'b0 || nt_bvalid !== 1'b1 || nt_outstanding !== 4'd6) begin bad++; $display("[TB] FAIL bp_resp_full: got v=%0b bvalid=%0b out=%0d required 0/1/6", nt_wr_valid, nt_bvalid, nt_outstanding); end
      j = 4;
      k = 0;
      BREADY = 1'b1;
      for (int c = 0; c < 60 && k < 6; c++) begin
         if (nt_wr_valid && j < 6) begin
            total++; if (nt_wr_addr !== addrs[j]) begin bad++; $display("[TB] FAIL bp_tail_order: got %0h required %0h", nt_wr_addr, addrs[j]); end
            iWriteAck = 1'b1; iWriteError = errs[j];
            j++;
         end else begin
            iWriteAck = 1'b0; iWriteError = 1'b0;
         end
         if (nt_bvalid) begin
            total++; if (nt_bresp !== (errs[k] ? 2'b10 : 2'b00)) begin bad++; $display("[TB] FAIL bp_resp_order: resp %0d got %0b required %0b", k, nt_bresp, errs[k] ? 2'b10 : 2'b00); end
            k++;
         end
         tick();
      end
      iWriteAck = 1'b0; iWriteError = 1'b0; BREADY = 1'b0;
      total++; if (k !== 6 || nt_outstanding !== 4'd0 || nt_bvalid !== 1'b0) begin bad++; $display("[TB] FAIL bp_all_returned: got count=%0d out=%0d bvalid=%0b required 6/0/0", k, nt_outstanding, nt_bvalid); end
   endtask

   task automatic test_reset_mid_operation();
      bit seen;
      for (int i = 0; i < 3; i++) send(32'h200 + 32'(4 * i), 32'h55 + 32'(i), 4'h1, 1'b0);
      tick();
      total++; if (outstanding !== 4'd3) begin bad++; $display("[TB] FAIL midreset_queued: got %0d required 3", outstanding); end
      ARESETN = 1'b0;
      tick();
      ARESETN = 1'b1;
      total++; if (awready !== 1'b0 || wr_valid !== 1'b0 || bvalid !== 1'b0 || outstanding !== 4'd0 || wr_addr !== 32'h0 || bresp !== 2'b00) begin bad++; $display("[TB] FAIL midreset_values: got aw=%0b v=%0b bvalid=%0b out=%0d a=%0h resp=%0b required all 0", awready, wr_valid, bvalid, outstanding, wr_addr, bresp); end
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         seen |= bvalid;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL midreset_no_b: got bvalid seen=%0b required 0", seen); end
      send(32'h300, 32'h0BADF00D, 4'hC, 1'b0);
      tick();
      total++; if (wr_valid !== 1'b1 || wr_addr !== 32'h300 || wr_data !== 32'h0BADF00D || wr_strb !== 4'hC || outstanding !== 4'd1) begin bad++; $display("[TB] FAIL midreset_new_head: got v=%0b a=%0h d=%0h s=%0h out=%0d required 1/300/badf00d/c/1", wr_valid, wr_addr, wr_data, wr_strb, outstanding); end
      iWriteAck = 1'b1;
      tick();
      iWriteAck = 1'b0;
      total++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin bad++; $display("[TB] FAIL midreset_new_resp: got bvalid=%0b resp=%0b required 1/00", bvalid, bresp); end
      drain();
      total++; if (outstanding !== 4'd0) begin bad++; $display("[TB] FAIL midreset_drained: got %0d required 0", outstanding); end
   endtask

   // Runs every scenario in order and prints the summary.
   initial begin
      test_reset();
      test_single_write();
      test_decoupled();
      test_error_path();
      test_timeout();
      test_back_to_back();
      test_reset_mid_operation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
